// File: rtl/top_el_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: widths, opcodes,
// controller phases, control-word layout and the ALU function.
package top_el_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int PHASE_W = 3;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic halt;
        logic inc_pc;
        logic ld_ac;
        logic ld_pc;
        logic wr;
        logic data_e;
    } ctrl_t;

    // Opcodes that read an operand from memory and update the accumulator.
    function automatic logic is_alu_op(opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    // Accumulator next value; opcodes without an ALU role pass AC through.
    function automatic logic [DATA_W-1:0] alu_fn(opcode_e op,
                                                 logic [DATA_W-1:0] ac,
                                                 logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] res;
        case (op)
            OP_ADD:  res = ac + data;
            OP_AND:  res = ac & data;
            OP_XOR:  res = ac ^ data;
            OP_LDA:  res = data;
            default: res = ac;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/top_el_top_memory.sv
// 32x8 unified code/data memory: combinational read, synchronous write.
// Contents are deliberately not reset so a preloaded program survives reset.
module top_el_top_memory
    import top_el_pkg::*;
(
    input  logic              clk_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] array [0:MEM_DEPTH-1];

    // Store the data bus at the addressed location when the controller writes.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            array[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = array[addr_i];

endmodule

// File: rtl/top_el_top.sv
// VeriRISC-style accumulator CPU: phase-sequenced controller, PC, IR, AC,
// ALU and the unified memory. Every instruction takes eight phases.
//
// phase | meaning
// ------+-------------------------------------------------------------
//   0   | INST_ADDR  : drive PC onto the memory address
//   1   | INST_FETCH : read instruction
//   2   | INST_LOAD  : latch instruction into IR
//   3   | IDLE       : hold IR load, instruction now decoded
//   4   | OP_ADDR    : PC+1; freeze here on HLT
//   5   | OP_FETCH   : read operand for ALU ops
//   6   | ALU_OP     : SKZ skip / JMP load / present AC for STO
//   7   | STORE      : AC update, JMP load, STO write
module top_el_top
    import top_el_pkg::*;
(
    input  logic i_top_clk,
    input  logic i_top_rst,
    output logic o_top_halt
);

    phase_e            phase_q, phase_d;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] ir_q, ac_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    opcode_e           opcode;
    logic              zero;
    logic              alu_op;

    assign opcode = opcode_e'(ir_q[7:5]);
    assign zero   = (ac_q == '0);
    assign alu_op = is_alu_op(opcode);

    // Phase register; reset aborts whatever instruction is in flight.
    always_ff @(posedge i_top_clk or negedge i_top_rst) begin
        if (!i_top_rst) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Advance one phase per clock, holding in OP_ADDR once halted.
    always_comb begin
        phase_d = phase_e'(phase_q + 3'd1);
        if (ctrl.halt) begin
            phase_d = phase_q;
        end
    end

    // Decode the control word from the current phase and opcode.
    always_comb begin
        ctrl = '0;
        case (phase_q)
            PH_INST_ADDR: begin
                ctrl.sel = 1'b1;
            end
            PH_INST_FETCH: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                ctrl.sel   = 1'b1;
                ctrl.rd    = 1'b1;
                ctrl.ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                ctrl.inc_pc = 1'b1;
                ctrl.halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
                ctrl.rd = alu_op;
            end
            PH_ALU_OP: begin
                ctrl.rd     = alu_op;
                ctrl.inc_pc = (opcode == OP_SKZ) && zero;
                ctrl.ld_pc  = (opcode == OP_JMP);
                ctrl.data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                ctrl.rd     = alu_op;
                ctrl.ld_ac  = alu_op;
                ctrl.ld_pc  = (opcode == OP_JMP);
                ctrl.data_e = (opcode == OP_STO);
                ctrl.wr     = (opcode == OP_STO);
            end
            default: ctrl = '0;
        endcase
    end

    assign o_top_halt = ctrl.halt;

    assign mem_addr = ctrl.sel ? pc_q : ir_q[ADDR_W-1:0];
    assign alu_res  = alu_fn(opcode, ac_q, bus);

    // Single data bus: memory drives it on reads, the accumulator on stores.
    always_comb begin
        bus = '0;
        if (ctrl.rd) begin
            bus = mem_rdata;
        end else if (ctrl.data_e) begin
            bus = ac_q;
        end
    end

    // Instruction, program counter and accumulator registers.
    always_ff @(posedge i_top_clk or negedge i_top_rst) begin
        if (!i_top_rst) begin
            ir_q <= '0;
            pc_q <= '0;
            ac_q <= '0;
        end else begin
            if (ctrl.ld_ir) begin
                ir_q <= bus;
            end
            if (ctrl.ld_pc) begin
                pc_q <= ir_q[ADDR_W-1:0];
            end else if (ctrl.inc_pc) begin
                pc_q <= pc_q + 5'd1;
            end
            if (ctrl.ld_ac) begin
                ac_q <= alu_res;
            end
        end
    end

    top_el_top_memory memory_inst (
        .clk_i   (i_top_clk),
        .wr_i    (ctrl.wr),
        .addr_i  (mem_addr),
        .wdata_i (bus),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_top_el_top.sv
// Directed-program bench for the accumulator CPU. The stimulus side loads
// programs and queues expected events; a monitor consumes the queue on each
// falling edge and compares what the CPU presents.
module tb_top_el_top;

    localparam int K_LOW  = 0;   // halt must be low now
    localparam int K_HIGH = 1;   // halt must be high now
    localparam int K_RISE = 2;   // halt must first rise after exactly N edges
    localparam int K_MEM  = 3;   // memory word must hold a value

    localparam int OP_HLT = 0, OP_SKZ = 1, OP_ADD = 2, OP_AND = 3;
    localparam int OP_XOR = 4, OP_LDA = 5, OP_STO = 6, OP_JMP = 7;

    typedef struct {
        int         kind;
        int         edges;
        int         addr;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    logic halt;

    exp_t  exp_q[$];
    string name_q[$];
    int    edge_cnt;
    int    tests;
    int    failed;

    top_el_top dut (
        .i_top_clk  (clk),
        .i_top_rst  (rst_n),
        .o_top_halt (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [7:0] ins(int op, int a);
        logic [7:0] r;
        r = {op[2:0], a[4:0]};
        return r;
    endfunction

    task automatic push(int kind, int edges, int addr, logic [7:0] val, string nm);
        exp_t e;
        e.kind  = kind;
        e.edges = edges;
        e.addr  = addr;
        e.val   = val;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_stall: %0d items pending, required 0", exp_q.size());
            $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
            $fatal(1, "scoreboard stalled");
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) dut.memory_inst.array[i] = 8'h00;
    endtask

    task automatic poke(int a, logic [7:0] v);
        dut.memory_inst.array[a] = v;
    endtask

    // Hold reset with the program loaded, check halt is low, then run.
    task automatic run_prog(string nm, int rise_edges);
        push(K_LOW, 0, 0, 8'h00, {nm, "_rst"});
        drain();
        push(K_RISE, rise_edges, 0, 8'h00, nm);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drain();
    endtask

    // Monitor: compares the head of the expectation queue on each falling edge.
    initial begin
        exp_t  cur;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                nm  = name_q[0];
                case (cur.kind)
                    K_LOW, K_HIGH: begin
                        tests++;
                        if (halt !== (cur.kind == K_HIGH)) begin
                            failed++;
                            $display("FAIL %s: halt=%b, required %0d", nm, halt, cur.kind == K_HIGH);
                        end
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                    end
                    K_MEM: begin
                        tests++;
                        if (dut.memory_inst.array[cur.addr] !== cur.val) begin
                            failed++;
                            $display("FAIL %s: mem[%0d]=%h, required %h", nm, cur.addr,
                                     dut.memory_inst.array[cur.addr], cur.val);
                        end
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                    end
                    default: begin
                        if (halt === 1'b1) begin
                            tests++;
                            if (edge_cnt != cur.edges) begin
                                failed++;
                                $display("FAIL %s: halt rose after %0d edges, required %0d", nm, edge_cnt, cur.edges);
                            end
                            void'(exp_q.pop_front());
                            void'(name_q.pop_front());
                        end else if (edge_cnt > cur.edges + 16) begin
                            tests++;
                            failed++;
                            $display("FAIL %s: no halt after %0d edges, required at %0d", nm, edge_cnt, cur.edges);
                            void'(exp_q.pop_front());
                            void'(name_q.pop_front());
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exhausted, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);

        // HLT at address 0: halt after 4 edges, then stays frozen.
        enter_reset();
        run_prog("hlt", 4);
        repeat (5) @(negedge clk);
        push(K_HIGH, 0, 0, 8'h00, "hlt_frozen");
        drain();
        // Asynchronous reset: assert just after a rising edge, sample before the next one.
        @(posedge clk);
        #1 rst_n = 1'b0;
        push(K_LOW, 0, 0, 8'h00, "async_rst");
        drain();

        // JMP 2 twice, HLT at 2.
        enter_reset();
        poke(0, ins(OP_JMP, 2));
        poke(1, ins(OP_JMP, 2));
        run_prog("jmp", 12);

        // SKZ with AC=0 skips the JMP at 1.
        enter_reset();
        poke(0, ins(OP_SKZ, 0));
        poke(1, ins(OP_JMP, 2));
        run_prog("skz", 12);

        // LDA/STO round trip, SKZ not taken, HLT at 4.
        enter_reset();
        poke(0, ins(OP_LDA, 7));
        poke(1, ins(OP_STO, 8));
        poke(2, ins(OP_LDA, 8));
        poke(3, ins(OP_SKZ, 0));
        poke(4, ins(OP_HLT, 0));
        poke(5, ins(OP_JMP, 6));
        poke(6, ins(OP_HLT, 0));
        poke(7, 8'h01);
        poke(8, 8'h00);
        run_prog("lda_sto", 36);
        push(K_MEM, 0, 8, 8'h01, "lda_sto_mem");
        drain();

        // AND: ff&01 nonzero, then &fe zero; traps at 4 and 7.
        enter_reset();
        poke(0, ins(OP_LDA, 20));
        poke(1, ins(OP_AND, 21));
        poke(2, ins(OP_SKZ, 0));
        poke(3, ins(OP_JMP, 5));
        poke(5, ins(OP_AND, 22));
        poke(6, ins(OP_SKZ, 0));
        poke(8, ins(OP_JMP, 9));
        poke(20, 8'hff);
        poke(21, 8'h01);
        poke(22, 8'hfe);
        run_prog("and", 60);

        // XOR: 55^54 nonzero, then ^01 zero; same control flow.
        enter_reset();
        poke(0, ins(OP_LDA, 20));
        poke(1, ins(OP_XOR, 21));
        poke(2, ins(OP_SKZ, 0));
        poke(3, ins(OP_JMP, 5));
        poke(5, ins(OP_XOR, 22));
        poke(6, ins(OP_SKZ, 0));
        poke(8, ins(OP_JMP, 9));
        poke(20, 8'h55);
        poke(21, 8'h54);
        poke(22, 8'h01);
        run_prog("xor", 60);

        // ADD wrap: ff+01=00 skips trap at 3; +01=01 does not skip.
        enter_reset();
        poke(0, ins(OP_LDA, 20));
        poke(1, ins(OP_ADD, 21));
        poke(2, ins(OP_SKZ, 0));
        poke(4, ins(OP_ADD, 21));
        poke(5, ins(OP_SKZ, 0));
        poke(20, 8'hff);
        poke(21, 8'h01);
        run_prog("add_wrap", 44);

        // ADD result stored: 3c+d7 = 113 -> 13.
        enter_reset();
        poke(0, ins(OP_LDA, 20));
        poke(1, ins(OP_ADD, 21));
        poke(2, ins(OP_STO, 22));
        poke(20, 8'h3c);
        poke(21, 8'hd7);
        poke(22, 8'haa);
        run_prog("add_sto", 28);
        push(K_MEM, 0, 22, 8'h13, "add_sto_mem");
        drain();

        // Reset during STO's STORE phase must prevent the write.
        enter_reset();
        poke(0, ins(OP_LDA, 20));
        poke(1, ins(OP_STO, 21));
        poke(20, 8'h5a);
        poke(21, 8'h11);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        push(K_MEM, 0, 21, 8'h11, "sto_abort");
        push(K_LOW, 0, 0, 8'h00, "sto_abort_halt");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/top_el_top.md
# top_el_top

Top level of the VeriRISC-style 8-bit accumulator CPU. It integrates the phase counter, controller, program counter, instruction register, accumulator, ALU and a 32x8 unified instruction/data memory. Each instruction runs in exactly 8 clock phases. The only primary output is a halt indicator.

## Interface
- No parameters. Fixed widths: data 8, address 5, opcode 3, phase 3.
- i_top_clk  in  1  single system clock; all state updates on rising edge.
- i_top_rst  in  1  asynchronous, active-low reset.
- o_top_halt  out  1  high while a HLT instruction is in its execute phases.

## Operation
- Instruction format: [7:5] opcode, [4:0] address/operand.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Memory is 32x8 and holds both code and data.
  - It is instantiated as memory_inst; its storage is a reg vector array named `array` [0:31].
  - The bench preloads `array` hierarchically.
  - Memory contents are not affected by reset.
- Address mux: sel=1 selects PC, sel=0 selects IR[4:0].
- Data bus: memory read data when rd=1; accumulator when data_e=1.
- zero = (AC == 8'h00), combinational.
- ALU result by opcode:
  - ADD: AC+data, mod 256, carry discarded.
  - AND: AC&data.
  - XOR: AC^data.
  - LDA: data.
  - All other opcodes: AC unchanged.
- Controller states are the phase values 0..7:
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc, halt if HLT.
  - 5 OP_FETCH: rd if ALU op (ADD/AND/XOR/LDA).
  - 6 ALU_OP: rd if ALU op; inc_pc if SKZ&&zero; ld_pc if JMP; data_e if STO.
  - 7 STORE: rd and ld_ac if ALU op; ld_pc if JMP; data_e and wr if STO.
- Register updates:
  - IR loads on ld_ir.
  - PC: ld_pc loads IR[4:0]; else inc_pc increments, wrapping 31->0.
  - AC loads the ALU result on ld_ac.
  - Memory writes the bus at IR[4:0] on wr, synchronously.

## Timing
- Reset (i_top_rst=0), asynchronous:
  - phase=0, PC=0, IR=0, AC=0.
  - o_top_halt=0, since IR=0 but phase is not 4.
- Phase counter advances by 1 per clock, wrapping 7->0, while halt=0.
- When halt=1 the counter freezes at phase 4, so o_top_halt stays 1 until reset.
- The first rising edge after reset release moves phase 0->1.
- o_top_halt is combinational from phase and IR, asserted in phase 4.
  - A HLT at address 0 raises halt 4 edges after reset release.
  - Every completed instruction before it adds 8 edges.
- A JMP takes effect at the end of its phase 7; the next fetch uses the new PC.
- SKZ with zero=1 increments PC twice (phases 4 and 6), skipping one instruction.
- Reset mid-instruction aborts it immediately. Partial stores cannot occur, because wr is only active in phase 7.

## Structure
- Shared package: opcode constants (HLT..JMP), phase/state encodings, widths (DATA_W=8, ADDR_W=5).
- Sub-module: memory (instance memory_inst, array `array`). It is required for bench access.
- Controller, ALU, counters and registers may be inline or small sub-modules.

## Test plan
- Reset, with mem[0]={HLT,x}: o_top_halt=0 after release plus 1 clock; after 2 more clocks halt=0; after 1 more clock halt=1.
- JMP, with mem[0]=mem[1]={JMP,2}, mem[2]=HLT: halt=0 at 10 clocks after the reset sequence and 1 at 11.
- SKZ, with mem[0]=SKZ, mem[1]={JMP,2}, mem[2]=HLT: halt at clock 11 (10 -> 0).
- LDA/STO:
  - Program: LDA 7 (=1); STO 8; LDA 8; SKZ; HLT; JMP 6; HLT at 6; mem[8]=0.
  - Required: halt=0 at 34 clocks, 1 at 35; mem[8]=1 afterwards.
- AND/XOR:
  - Program: LDA ff; AND 01 (nonzero); SKZ; JMP 5; AND fe (zero) at 5; SKZ skips; JMP 9; HLT at 9.
  - Required: halt at clock 59 (58 -> 0). The same program with XOR 55/54/01 gives identical timing.
- ADD wrap: LDA ff; ADD 01 gives 0, so SKZ skips; ADD 01 gives 1, so no skip; HLT at 6. Required: halt=0 at 42 clocks, 1 at 43.
